chrono_interval_ctrl: RTL and testbench
=======================================

# chrono_interval_ctrl

Sequencer for the stopwatch core. It accepts an interval target (minutes:seconds) through a valid/ready config port. On a go pulse it drives the stopwatch through reset, start, run-to-target and stop, and optionally repeats the interval. It sits between the control/host logic and the stopwatch, and is the only source of the stopwatch's start/stop/reset command pulses.

## Interface
- ACK_TIMEOUT, 16: cycles a wait state tolerates before flagging an error (only with CHRONO_ACK_TIMEOUT_EN)
- i_sys_clk  in  1  system clock, rising edge
- i_hw_reset_n  in  1  reset, asynchronous, active-low
- i_cfg_valid  in  1  config offer
- o_cfg_ready  out  1  config accept; high only in IDLE
- i_cfg_min  in  8  target minutes
- i_cfg_sec  in  6  target seconds; values >59 are clamped to 59 on capture
- i_cfg_repeat  in  1  auto-repeat interval
- i_go  in  1  start sequence (pulse)
- i_abort  in  1  abort sequence (pulse)
- i_val_min  in  8  stopwatch minutes
- i_val_sec  in  6  stopwatch seconds
- i_fsm_state  in  2  stopwatch state: 00 IDLE, 01 RUNNING, 10 PAUSED
- o_cmd_start / o_cmd_stop / o_cmd_reset  out  1 each  single-cycle registered command pulses to the stopwatch
- o_done  out  1  one-cycle pulse per completed interval
- o_busy  out  1  high in any state other than IDLE
- o_rep_count  out  8  completed intervals since last go; saturates at 255
- o_err  out  1  sticky timeout flag
- o_ctrl_state  out  3  IDLE 0, ARM 1, START 2, RUN 3, STOP 4, DONE 5, ERR 6

## Operation
- Reset values:
  - state IDLE.
  - o_cfg_ready=1.
  - All other outputs 0.
  - Target 0:00, repeat 0, loaded flag 0.
- Config handshake: transfer on i_cfg_valid && o_cfg_ready. It captures min, clamped sec and repeat, and sets the loaded flag.
- IDLE:
  - i_go with loaded flag set → ARM. o_rep_count clears to 0.
  - i_go without loaded flag is ignored.
- Zero target (0:00): go → DONE directly. No commands are issued. o_done pulses once. No repeat.
- ARM:
  - o_cmd_reset is high on the first ARM cycle only.
  - From the second cycle: i_fsm_state==00, i_val_min==0 and i_val_sec==0 → START.
- START:
  - o_cmd_start is high on the first START cycle.
  - From the second cycle: i_fsm_state==01 → RUN.
- RUN: {i_val_min,i_val_sec} ≥ {target_min,target_sec} (14-bit unsigned compare, min as MSBs) → STOP.
- STOP:
  - o_cmd_stop is high on the first STOP cycle.
  - From the second cycle: i_fsm_state==10 → DONE.
- DONE:
  - o_done=1 for one cycle. o_rep_count increments, saturating at 255.
  - Repeat set → ARM next cycle. Otherwise → IDLE.
- Abort:
  - i_abort in any non-IDLE state → o_cmd_reset pulse next cycle, state IDLE.
  - No o_done. o_rep_count holds.
- Priority in IDLE: abort over go (abort suppresses go). Config capture and go in the same cycle → go uses the newly captured config.
- Config offered while busy: o_cfg_ready=0, so it stalls until IDLE.

## Timing
- All outputs are registered, except o_cfg_ready and o_busy, which are decoded from state.
- go at edge N → ARM at N+1, o_cmd_reset high during cycle N+1.
- Minimum command-to-acknowledge window is one cycle. The stopwatch updates i_fsm_state the cycle after a command.
- RUN compare detects the target the cycle after the stopwatch outputs reach it. o_cmd_stop follows one cycle later. Worst-case overshoot at the stopwatch is 2 cycles, never a full second.
- Reset assertion mid-sequence forces IDLE asynchronously. No command pulse is emitted.

## Configuration
- CHRONO_ACK_TIMEOUT_EN defined:
  - ARM, START and STOP each count cycles from entry.
  - Reaching ACK_TIMEOUT without the acknowledge condition → ERR. ERR issues an o_cmd_reset pulse and sets o_err=1.
  - ERR → IDLE on the next cycle. o_err stays high until the next accepted config or an abort.
- CHRONO_ACK_TIMEOUT_EN undefined: wait states wait indefinitely, o_err is tied 0, and the ERR state is unreachable.

## Test plan
- Config 0:03, repeat 0, go, ideal stopwatch model → reset, start and stop pulses in order. Stop is issued when the stopwatch reads 0:03. o_done pulses once, o_rep_count=1, state returns to IDLE.
- Config 0:02, repeat 1, let 3 intervals complete, then abort → three o_done pulses, o_rep_count=3. Abort yields an o_cmd_reset pulse, IDLE, and no extra o_done.
- Config with i_cfg_sec=63 → captured as 59. Config 0:00 + go → o_done within 2 cycles and no command pulses.
- i_go after reset with no config → ignored, state stays IDLE. i_abort and i_go in the same IDLE cycle → stays IDLE.
- With CHRONO_ACK_TIMEOUT_EN: stopwatch model never enters RUNNING → ERR after 16 cycles in START, o_err=1, o_cmd_reset pulse, IDLE. Next config accept clears o_err.
- Async reset asserted in RUN → all outputs 0 and o_cfg_ready=1 immediately. No command pulses after release.

Source files
------------

// File: rtl/chrono_interval_ctrl_if.sv
// ---------------------------------------------------------------------------
// chrono_interval_ctrl_if
//   Configuration handshake bundle between the host/control logic and the
//   interval sequencer. A transfer happens on a rising clock edge where
//   i_cfg_valid and o_cfg_ready are both high.
//
//   i_cfg_valid   host -> ctrl  config offer
//   o_cfg_ready   ctrl -> host  config accept (sequencer idle)
//   i_cfg_min     host -> ctrl  target minutes
//   i_cfg_sec     host -> ctrl  target seconds (clamped to 59 on capture)
//   i_cfg_repeat  host -> ctrl  auto-repeat the interval
//
//   modport master : host side
//   modport slave  : sequencer side
// ---------------------------------------------------------------------------
interface chrono_interval_ctrl_if;
  logic       i_cfg_valid;
  logic       o_cfg_ready;
  logic [7:0] i_cfg_min;
  logic [5:0] i_cfg_sec;
  logic       i_cfg_repeat;

  modport master (
    output i_cfg_valid, i_cfg_min, i_cfg_sec, i_cfg_repeat,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid, i_cfg_min, i_cfg_sec, i_cfg_repeat,
    output o_cfg_ready
  );
endinterface

// File: rtl/chrono_interval_ctrl.sv
// ---------------------------------------------------------------------------
// chrono_interval_ctrl
//   Interval sequencer for the stopwatch core. A target (min:sec) is loaded
//   through the cfg handshake; a go pulse then walks the stopwatch through
//   reset -> start -> run-to-target -> stop, optionally repeating. This block
//   is the only source of the stopwatch's command pulses.
//
//   Optional feature macro: CHRONO_ACK_TIMEOUT_EN
//     defined   : ARM/START/STOP give up after ACK_TIMEOUT cycles without an
//                 acknowledge, pass through ERR (reset pulse) and set o_err.
//     undefined : wait states wait forever, o_err is constant 0.
//
//   Ports
//     i_sys_clk      system clock, rising edge
//     i_hw_reset_n   asynchronous active-low reset
//     cfg            config handshake (slave modport)
//     i_go/i_abort   sequence start / abort pulses
//     i_val_min/sec  current stopwatch reading
//     i_fsm_state    stopwatch state: 00 idle, 01 running, 10 paused
//     o_cmd_*        single-cycle registered command pulses to stopwatch
//     o_done         one-cycle pulse per completed interval
//     o_busy         sequencer not idle
//     o_rep_count    completed intervals since last go (saturating)
//     o_err          sticky acknowledge-timeout flag
//     o_ctrl_state   IDLE 0, ARM 1, START 2, RUN 3, STOP 4, DONE 5, ERR 6
// ---------------------------------------------------------------------------
module chrono_interval_ctrl
`ifdef CHRONO_ACK_TIMEOUT_EN
#(
  parameter int unsigned ACK_TIMEOUT = 16
)
`endif
(
  input  logic                   i_sys_clk,
  input  logic                   i_hw_reset_n,
  chrono_interval_ctrl_if.slave  cfg,
  input  logic                   i_go,
  input  logic                   i_abort,
  input  logic [7:0]             i_val_min,
  input  logic [5:0]             i_val_sec,
  input  logic [1:0]             i_fsm_state,
  output logic                   o_cmd_start,
  output logic                   o_cmd_stop,
  output logic                   o_cmd_reset,
  output logic                   o_done,
  output logic                   o_busy,
  output logic [7:0]             o_rep_count,
  output logic                   o_err,
  output logic [2:0]             o_ctrl_state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] SW_IDLE    = 2'b00;
  localparam logic [1:0] SW_RUNNING = 2'b01;
  localparam logic [1:0] SW_PAUSED  = 2'b10;

  state_t     state_q, state_d;
  logic       first_q, first_d;       // first cycle after any state change
  logic [7:0] tgt_min_q, tgt_min_d;
  logic [5:0] tgt_sec_q, tgt_sec_d;
  logic       rep_q, rep_d;
  logic       loaded_q, loaded_d;
  logic       cmd_start_q, cmd_start_d;
  logic       cmd_stop_q, cmd_stop_d;
  logic       cmd_reset_q, cmd_reset_d;
  logic       done_q, done_d;
  logic [7:0] rep_count_q, rep_count_d;

  logic       cfg_fire;
  logic       tgt_zero;
  logic       timeout_hit;

`ifdef CHRONO_ACK_TIMEOUT_EN
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
`endif

  assign cfg_fire = cfg.i_cfg_valid && (state_q == ST_IDLE);

  // The timer restarts on every state change, so in a wait state it holds
  // the number of cycles spent there; it only matters in ARM/START/STOP.
`ifdef CHRONO_ACK_TIMEOUT_EN
  assign timeout_hit = (timer_q == TW'(ACK_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    tgt_min_d   = tgt_min_q;
    tgt_sec_d   = tgt_sec_q;
    rep_d       = rep_q;
    loaded_d    = loaded_q;
    cmd_start_d = 1'b0;
    cmd_stop_d  = 1'b0;
    cmd_reset_d = 1'b0;
    done_d      = 1'b0;
    rep_count_d = rep_count_q;
`ifdef CHRONO_ACK_TIMEOUT_EN
    err_d       = err_q;
`endif

    if (cfg_fire) begin
      tgt_min_d = cfg.i_cfg_min;
      tgt_sec_d = (cfg.i_cfg_sec > 6'd59) ? 6'd59 : cfg.i_cfg_sec;
      rep_d     = cfg.i_cfg_repeat;
      loaded_d  = 1'b1;
`ifdef CHRONO_ACK_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end

    // Uses the _d target so a go in the capture cycle sees the new config.
    tgt_zero = (tgt_min_d == 8'd0) && (tgt_sec_d == 6'd0);

    case (state_q)
      ST_IDLE: begin
        if (i_go && !i_abort && loaded_d) begin
          rep_count_d = 8'd0;
          state_d     = tgt_zero ? ST_DONE : ST_ARM;
        end
      end
      // Acknowledge checks skip the first cycle: the stopwatch only reacts
      // to a command on the edge after it is issued.
      ST_ARM: begin
        if (!first_q && i_fsm_state == SW_IDLE &&
            i_val_min == 8'd0 && i_val_sec == 6'd0)
          state_d = ST_START;
        else if (timeout_hit)
          state_d = ST_ERR;
      end
      ST_START: begin
        if (!first_q && i_fsm_state == SW_RUNNING)
          state_d = ST_START == ST_START ? ST_RUN : ST_RUN;
        else if (timeout_hit)
          state_d = ST_ERR;
      end
      ST_RUN: begin
        if ({i_val_min, i_val_sec} >= {tgt_min_q, tgt_sec_q})
          state_d = ST_STOP;
      end
      ST_STOP: begin
        if (!first_q && i_fsm_state == SW_PAUSED)
          state_d = ST_DONE;
        else if (timeout_hit)
          state_d = ST_ERR;
      end
      ST_DONE: begin
        // A zero target never repeats: there would be nothing to time.
        state_d = (rep_q && !tgt_zero) ? ST_ARM : ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Entry actions: every command/done pulse is tied to entering a state,
    // which keeps each one exactly one cycle long and registered.
    if (state_d != state_q) begin
      first_d = 1'b1;
      case (state_d)
        ST_ARM:   cmd_reset_d = 1'b1;
        ST_START: cmd_start_d = 1'b1;
        ST_STOP:  cmd_stop_d  = 1'b1;
        ST_DONE: begin
          done_d = 1'b1;
          if (rep_count_d != 8'hFF)
            rep_count_d = rep_count_d + 8'd1;
        end
        ST_ERR: begin
          cmd_reset_d = 1'b1;
`ifdef CHRONO_ACK_TIMEOUT_EN
          err_d       = 1'b1;
`endif
        end
        default: ;
      endcase
    end

    // Abort overrides whatever the sequence was about to do.
    if (i_abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      first_d     = 1'b1;
      cmd_reset_d = 1'b1;
      cmd_start_d = 1'b0;
      cmd_stop_d  = 1'b0;
      done_d      = 1'b0;
      rep_count_d = rep_count_q;
    end
`ifdef CHRONO_ACK_TIMEOUT_EN
    if (i_abort)
      err_d = 1'b0;
    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
`endif
  end

  always_ff @(posedge i_sys_clk or negedge i_hw_reset_n) begin
    if (!i_hw_reset_n) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      tgt_min_q   <= 8'd0;
      tgt_sec_q   <= 6'd0;
      rep_q       <= 1'b0;
      loaded_q    <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_stop_q  <= 1'b0;
      cmd_reset_q <= 1'b0;
      done_q      <= 1'b0;
      rep_count_q <= 8'd0;
`ifdef CHRONO_ACK_TIMEOUT_EN
      timer_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      tgt_min_q   <= tgt_min_d;
      tgt_sec_q   <= tgt_sec_d;
      rep_q       <= rep_d;
      loaded_q    <= loaded_d;
      cmd_start_q <= cmd_start_d;
      cmd_stop_q  <= cmd_stop_d;
      cmd_reset_q <= cmd_reset_d;
      done_q      <= done_d;
      rep_count_q <= rep_count_d;
`ifdef CHRONO_ACK_TIMEOUT_EN
      timer_q     <= timer_d;
      err_q       <= err_d;
`endif
    end
  end

  assign cfg.o_cfg_ready = (state_q == ST_IDLE);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_ctrl_state    = state_q;
  assign o_cmd_start     = cmd_start_q;
  assign o_cmd_stop      = cmd_stop_q;
  assign o_cmd_reset     = cmd_reset_q;
  assign o_done          = done_q;
  assign o_rep_count     = rep_count_q;
`ifdef CHRONO_ACK_TIMEOUT_EN
  assign o_err           = err_q;
`else
  assign o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_chrono_interval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chrono_interval_ctrl
//   Drives chrono_interval_ctrl against a behavioural stopwatch and checks
//   each interval sequence against an expected event list built from the
//   target, repeat count and abort point.
// ---------------------------------------------------------------------------
module tb_chrono_interval_ctrl;
  localparam int TICK = 5;   // stopwatch cycles per second
  localparam byte EV_R = 8'h52;
  localparam byte EV_S = 8'h53;
  localparam byte EV_P = 8'h50;
  localparam byte EV_D = 8'h44;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       go, abort;
  logic [7:0] sw_min;
  logic [5:0] sw_sec;
  logic [1:0] sw_state;
  logic       o_cmd_start, o_cmd_stop, o_cmd_reset, o_done, o_busy, o_err;
  logic [7:0] o_rep_count;
  logic [2:0] o_ctrl_state;
  bit         sw_stall;

  chrono_interval_ctrl_if cfg_if();

  chrono_interval_ctrl dut (
    .i_sys_clk    (clk),
    .i_hw_reset_n (rst_n),
    .cfg          (cfg_if),
    .i_go         (go),
    .i_abort      (abort),
    .i_val_min    (sw_min),
    .i_val_sec    (sw_sec),
    .i_fsm_state  (sw_state),
    .o_cmd_start  (o_cmd_start),
    .o_cmd_stop   (o_cmd_stop),
    .o_cmd_reset  (o_cmd_reset),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_rep_count  (o_rep_count),
    .o_err        (o_err),
    .o_ctrl_state (o_ctrl_state)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal stopwatch: reacts to a command on the edge after it is issued.
  int tick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_state <= 2'b00; sw_min <= 8'd0; sw_sec <= 6'd0; tick <= 0;
    end else if (o_cmd_reset) begin
      sw_state <= 2'b00; sw_min <= 8'd0; sw_sec <= 6'd0; tick <= 0;
    end else if (o_cmd_start) begin
      if (!sw_stall) begin sw_state <= 2'b01; tick <= 0; end
    end else if (o_cmd_stop) begin
      sw_state <= 2'b10;
    end else if (sw_state == 2'b01) begin
      if (tick == TICK - 1) begin
        tick <= 0;
        if (sw_sec == 6'd59) begin sw_sec <= 6'd0; sw_min <= sw_min + 8'd1; end
        else sw_sec <= sw_sec + 6'd1;
      end else tick <= tick + 1;
    end
  end

  // Event log, sampled shortly after each active edge.
  byte        ev_q[$];
  logic [13:0] stop_q[$];
  always @(posedge clk) begin
    #2;
    if (o_cmd_reset) ev_q.push_back(EV_R);
    if (o_cmd_start) ev_q.push_back(EV_S);
    if (o_cmd_stop) begin ev_q.push_back(EV_P); stop_q.push_back({sw_min, sw_sec}); end
    if (o_done) ev_q.push_back(EV_D);
  end

  function automatic int count_ev(input byte c);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i] == c) n++;
    return n;
  endfunction

  function automatic int clamp_sec(input int s);
    return (s > 59) ? 59 : s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, o_ctrl_state, 0);
    check_val({tag, "_ready"}, cfg_if.o_cfg_ready, 1);
    check_val({tag, "_busy"}, o_busy, 0);
    check_val({tag, "_cmds"}, {o_cmd_start, o_cmd_stop, o_cmd_reset}, 0);
    check_val({tag, "_done"}, o_done, 0);
    check_val({tag, "_repcnt"}, o_rep_count, 0);
    check_val({tag, "_err"}, o_err, 0);
  endtask

  // One go-sequence: config, go, wait for n intervals, optional abort.
  task automatic run_seq(input int mn, input int sc, input bit rp, input int n_int,
                         input bit same_cycle, input int abort_dly);
    int  csec = clamp_sec(sc);
    bit  zero = (mn == 0) && (csec == 0);
    bit  do_abort = rp && !zero;
    int  n_exp = do_abort ? n_int : 1;
    int  exp_rc = (n_exp > 255) ? 255 : n_exp;
    int  cyc;
    byte exp_q[$];

    @(negedge clk);
    ev_q.delete(); stop_q.delete();
    cfg_if.i_cfg_valid  = 1'b1;
    cfg_if.i_cfg_min    = 8'(mn);
    cfg_if.i_cfg_sec    = 6'(sc);
    cfg_if.i_cfg_repeat = rp;
    if (same_cycle) go = 1'b1;
    @(negedge clk);
    cfg_if.i_cfg_valid = 1'b0;
    if (!same_cycle) begin go = 1'b1; @(negedge clk); end
    go = 1'b0;

    if (zero) begin
      check_val("zero_state", o_ctrl_state, 5);
      check_val("zero_done", o_done, 1);
    end else begin
      check_val("go_state", o_ctrl_state, 1);
      check_val("go_cmd_reset", o_cmd_reset, 1);
      check_val("go_ready", cfg_if.o_cfg_ready, 0);
      check_val("go_busy", o_busy, 1);
    end

    cyc = 0;
    while (count_ev(EV_D) < n_exp && cyc < 20000) begin @(negedge clk); cyc++; end
    check_val("done_wait", cyc < 20000, 1);

    if (do_abort) begin
      repeat (abort_dly) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_state", o_ctrl_state, 0);
      check_val("abort_cmd_reset", o_cmd_reset, 1);
      check_val("abort_repcnt", o_rep_count, exp_rc);
    end else begin
      cyc = 0;
      while (o_ctrl_state != 3'd0 && cyc < 100) begin @(negedge clk); cyc++; end
      check_val("idle_wait", cyc < 100, 1);
    end
    repeat (4) @(negedge clk);

    if (zero) exp_q.push_back(EV_D);
    else begin
      for (int i = 0; i < n_exp; i++) begin
        exp_q.push_back(EV_R); exp_q.push_back(EV_S);
        exp_q.push_back(EV_P); exp_q.push_back(EV_D);
      end
      if (do_abort) begin
        if (abort_dly == 1) exp_q.push_back(EV_R);
        exp_q.push_back(EV_R);
      end
    end

    check_val("end_state", o_ctrl_state, 0);
    check_val("end_ready", cfg_if.o_cfg_ready, 1);
    check_val("end_repcnt", o_rep_count, exp_rc);
    check_val("seq_len", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      if (ev_q[i] != exp_q[i]) check_val("seq_ev", ev_q[i], exp_q[i]);
    check_val("seq_match", ev_q == exp_q, 1);
    foreach (stop_q[i]) check_val("stop_value", stop_q[i], {8'(mn), 6'(csec)});
    $display("seq min=%0d sec=%0d rep=%0d n=%0d abort_dly=%0d events=%0d", mn, sc, rp, n_exp, abort_dly, ev_q.size());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, rp, n, dly;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; sw_stall = 1'b0;
    cfg_if.i_cfg_valid = 1'b0; cfg_if.i_cfg_min = 8'd0;
    cfg_if.i_cfg_sec = 6'd0; cfg_if.i_cfg_repeat = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // go with nothing loaded is ignored
    go = 1'b1; @(negedge clk); go = 1'b0;
    check_val("go_unloaded_state", o_ctrl_state, 0);
    check_val("go_unloaded_cmd", o_cmd_reset, 0);

    run_seq(0, 3, 0, 1, 0, 0);
    run_seq(0, 2, 1, 3, 0, 0);
    run_seq(0, 63, 0, 1, 1, 0);
    run_seq(0, 0, 0, 1, 0, 0);
    run_seq(0, 0, 1, 1, 1, 0);
    run_seq(1, 1, 0, 1, 0, 0);

    for (int k = 0; k < 10; k++) begin
      sc  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(56, 63)) : int'($urandom_range(0, 6));
      rp  = int'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      dly = int'($urandom_range(0, 1));
      run_seq(0, sc, rp[0], n, 1'($urandom_range(0, 1)), dly);
    end

    // rep_count saturation
    run_seq(0, 1, 1, 258, 0, 0);

    // abort and go together in IDLE with a loaded config
    @(negedge clk);
    ev_q.delete();
    abort = 1'b1; go = 1'b1;
    @(negedge clk);
    abort = 1'b0; go = 1'b0;
    check_val("abort_go_state", o_ctrl_state, 0);
    check_val("abort_go_cmd", o_cmd_reset, 0);
    repeat (3) @(negedge clk);
    check_val("abort_go_events", ev_q.size(), 0);

`ifdef CHRONO_ACK_TIMEOUT_EN
    begin
      int start_cycles = 0;
      int cyc = 0;
      sw_stall = 1'b1;
      cfg_if.i_cfg_valid = 1'b1; cfg_if.i_cfg_min = 8'd0;
      cfg_if.i_cfg_sec = 6'd3; cfg_if.i_cfg_repeat = 1'b0; go = 1'b1;
      @(negedge clk);
      cfg_if.i_cfg_valid = 1'b0; go = 1'b0;
      while (o_ctrl_state != 3'd6 && cyc < 200) begin
        if (o_ctrl_state == 3'd2) start_cycles++;
        @(negedge clk); cyc++;
      end
      check_val("to_reached_err", o_ctrl_state, 6);
      check_val("to_start_cycles", start_cycles, 16);
      check_val("to_err", o_err, 1);
      check_val("to_cmd_reset", o_cmd_reset, 1);
      @(negedge clk);
      check_val("to_idle", o_ctrl_state, 0);
      check_val("to_err_sticky", o_err, 1);
      sw_stall = 1'b0;
      cfg_if.i_cfg_valid = 1'b1;
      @(negedge clk);
      cfg_if.i_cfg_valid = 1'b0;
      check_val("to_err_cleared", o_err, 0);
      $display("timeout test start_cycles=%0d", start_cycles);
    end
`endif

    // asynchronous reset in RUN
    begin
      int cyc = 0;
      cfg_if.i_cfg_valid = 1'b1; cfg_if.i_cfg_min = 8'd0;
      cfg_if.i_cfg_sec = 6'd5; cfg_if.i_cfg_repeat = 1'b1; go = 1'b1;
      @(negedge clk);
      cfg_if.i_cfg_valid = 1'b0; go = 1'b0;
      while (o_ctrl_state != 3'd3 && cyc < 100) begin @(negedge clk); cyc++; end
      check_val("rst_run_reached", o_ctrl_state, 3);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("rst_in_run");
      @(negedge clk);
      rst_n = 1'b1;
      ev_q.delete();
      repeat (10) @(negedge clk);
      check_val("rst_run_no_cmds", ev_q.size(), 0);
      go = 1'b1; @(negedge clk); go = 1'b0;
      check_val("rst_run_unloaded", o_ctrl_state, 0);
      $display("async reset in RUN checked");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
